// File: rtl/dpram_pkg.sv
// Shared types and defaults for the DPRAM responder and its read pipeline.
package dpram_pkg;

  typedef enum {WRITE_FIRST, READ_FIRST} collision_mode_e;

  typedef enum logic [0:0] {CLEAR, READY} dpram_state_e;

  localparam int DATA_W_DEF       = 8;
  localparam int ADDR_W_DEF       = 8;
  localparam int READ_LATENCY_MAX = 4;

endpackage

// File: rtl/dpram_read_pipe.sv
// Delay line for read results: {valid, collision, data} shifted STAGES times.
// Data registers only load on valid so the output holds between pulses.
module dpram_read_pipe #(
  parameter int DATA_W = 8,
  parameter int STAGES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              coll_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic              coll_o,
  output logic [DATA_W-1:0] data_o
);

  if (STAGES == 0) begin : g_pass
    assign valid_o = valid_i;
    assign coll_o  = coll_i;
    assign data_o  = data_i;
  end else begin : g_pipe
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] coll_q;
    logic [DATA_W-1:0] data_q [STAGES];

    always_ff @(posedge clock) begin
      if (reset) begin
        valid_q <= '0;
        coll_q  <= '0;
        for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      end else begin
        valid_q[0] <= valid_i;
        coll_q[0]  <= coll_i;
        if (valid_i) data_q[0] <= data_i;
        for (int i = 1; i < STAGES; i++) begin
          valid_q[i] <= valid_q[i-1];
          coll_q[i]  <= coll_q[i-1];
          if (valid_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign valid_o = valid_q[STAGES-1];
    assign coll_o  = coll_q[STAGES-1];
    assign data_o  = data_q[STAGES-1];
  end

endmodule

// File: rtl/dpram_responder.sv
// DPRAM bus responder: self-clearing dual-port array with fixed read latency
// and same-address collision reporting.
module dpram_responder
  import dpram_pkg::*;
#(
  parameter int              DATA_W         = DATA_W_DEF,
  parameter int              ADDR_W         = ADDR_W_DEF,
  parameter int              READ_LATENCY   = 1,
  parameter collision_mode_e COLLISION_MODE = WRITE_FIRST,
  parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] write_address,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] read_address,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              collision,
  output logic              busy,
  output dpram_state_e      state_dbg
);

  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CLEAR_LAST = (ADDR_W + 1)'(DEPTH - 1);

  if (READ_LATENCY < 1 || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
    $error("dpram_responder: READ_LATENCY must be 1..%0d", READ_LATENCY_MAX);
  end

  dpram_state_e      state_q, state_d;
  logic [ADDR_W:0]   clear_addr_q, clear_addr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    if (state_q == CLEAR) begin
      clear_addr_d = clear_addr_q + (ADDR_W + 1)'(1);
      if (clear_addr_q == CLEAR_LAST) state_d = READY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= CLEAR;
      clear_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
    end
  end

  // The clear sweep owns the write port; bus writes only land once READY.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = write_address;
    mem_wdata = data_in;
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clear_addr_q[ADDR_W-1:0];
        mem_wdata = INIT_VALUE;
      end else begin
        mem_we = write_enable;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  logic              rd_fire, rd_coll;
  logic [DATA_W-1:0] rd_data;

  assign rd_fire = (state_q == READY) && read_enable;
  assign rd_coll = rd_fire && write_enable && (read_address == write_address);
  assign rd_data = (COLLISION_MODE == WRITE_FIRST && rd_coll) ? data_in
                                                              : mem_q[read_address];

  logic              s0_valid_q, s0_coll_q;
  logic [DATA_W-1:0] s0_data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      s0_valid_q <= 1'b0;
      s0_coll_q  <= 1'b0;
      s0_data_q  <= '0;
    end else begin
      s0_valid_q <= rd_fire;
      s0_coll_q  <= rd_coll;
      if (rd_fire) s0_data_q <= rd_data;
    end
  end

  dpram_read_pipe #(
    .DATA_W(DATA_W),
    .STAGES(READ_LATENCY - 1)
  ) u_read_pipe (
    .clock  (clock),
    .reset  (reset),
    .valid_i(s0_valid_q),
    .coll_i (s0_coll_q),
    .data_i (s0_data_q),
    .valid_o(data_valid),
    .coll_o (collision),
    .data_o (data_out)
  );

  assign busy      = (state_q == CLEAR);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dpram_responder.sv
// Bench for dpram_responder: three instances (latency 1/3/2, write-first and
// read-first) share one stimulus stream; each has its own expected queue.
module tb_dpram_responder;
  import dpram_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       write_enable = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] write_address = '0;
  logic       read_enable = 1'b0;
  logic [7:0] read_address = '0;

  logic [7:0] a_dout, b_dout, c_dout;
  logic       a_valid, b_valid, c_valid;
  logic       a_coll, b_coll, c_coll;
  logic       a_busy, b_busy, c_busy;
  dpram_state_e a_state, b_state, c_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0] exp_a_q[$], exp_b_q[$], exp_c_q[$];
  int         iss_a_q[$], iss_b_q[$], iss_c_q[$];

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dpram_responder #(.READ_LATENCY(1), .COLLISION_MODE(WRITE_FIRST)) dut_a (
    .clock(clock), .reset(reset), .write_enable(write_enable), .data_in(data_in),
    .write_address(write_address), .read_enable(read_enable), .read_address(read_address),
    .data_out(a_dout), .data_valid(a_valid), .collision(a_coll), .busy(a_busy),
    .state_dbg(a_state));

  dpram_responder #(.READ_LATENCY(3), .COLLISION_MODE(READ_FIRST)) dut_b (
    .clock(clock), .reset(reset), .write_enable(write_enable), .data_in(data_in),
    .write_address(write_address), .read_enable(read_enable), .read_address(read_address),
    .data_out(b_dout), .data_valid(b_valid), .collision(b_coll), .busy(b_busy),
    .state_dbg(b_state));

  dpram_responder #(.READ_LATENCY(2), .COLLISION_MODE(WRITE_FIRST)) dut_c (
    .clock(clock), .reset(reset), .write_enable(write_enable), .data_in(data_in),
    .write_address(write_address), .read_enable(read_enable), .read_address(read_address),
    .data_out(c_dout), .data_valid(c_valid), .collision(c_coll), .busy(c_busy),
    .state_dbg(c_state));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    write_enable  = 1'b1;
    write_address = addr;
    data_in       = data;
    @(posedge clock); #1;
    write_enable  = 1'b0;
  endtask

  // Queues {collision, data} per instance; pa/pb/pc select which expect a reply.
  task automatic rd(input logic [7:0] addr, input logic [8:0] ea, input logic [8:0] eb,
                    input logic [8:0] ec, input bit pa, input bit pb, input bit pc);
    if (pa) begin exp_a_q.push_back(ea); iss_a_q.push_back(cyc + 1); end
    if (pb) begin exp_b_q.push_back(eb); iss_b_q.push_back(cyc + 1); end
    if (pc) begin exp_c_q.push_back(ec); iss_c_q.push_back(cyc + 1); end
    read_enable  = 1'b1;
    read_address = addr;
    @(posedge clock); #1;
    read_enable  = 1'b0;
  endtask

  task automatic rd_all(input logic [7:0] addr, input logic [8:0] e);
    rd(addr, e, e, e, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic count_busy(output int na, output int nb, output int nc);
    na = 0; nb = 0; nc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (a_busy) na++;
      if (b_busy) nb++;
      if (c_busy) nc++;
      if (!a_busy && !b_busy && !c_busy) break;
    end
  endtask

  // scoreboard monitors
  always @(negedge clock) begin
    if (a_valid === 1'b1) begin
      if (exp_a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_valid: got data 0x%0h, required no data_valid", a_dout);
      end else begin
        check("a_data", {23'b0, a_coll, a_dout}, {23'b0, exp_a_q.pop_front()});
        check("a_latency", cyc - iss_a_q.pop_front(), 0);
      end
    end
  end

  always @(negedge clock) begin
    if (b_valid === 1'b1) begin
      if (exp_b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_valid: got data 0x%0h, required no data_valid", b_dout);
      end else begin
        check("b_data", {23'b0, b_coll, b_dout}, {23'b0, exp_b_q.pop_front()});
        check("b_latency", cyc - iss_b_q.pop_front(), 2);
      end
    end
  end

  always @(negedge clock) begin
    if (c_valid === 1'b1) begin
      if (exp_c_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL c_unexpected_valid: got data 0x%0h, required no data_valid", c_dout);
      end else begin
        check("c_data", {23'b0, c_coll, c_dout}, {23'b0, exp_c_q.pop_front()});
        check("c_latency", cyc - iss_c_q.pop_front(), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb, nc;

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_a_busy", a_busy, 1);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_dout", a_dout, 8'h00);
    check("rst_b_valid", b_valid, 0);
    check("rst_c_busy", c_busy, 1);
    check("rst_c_dout", c_dout, 8'h00);
    @(posedge clock); #1;
    reset = 1'b0;

    // clear phase, with requests issued while busy that must be ignored
    fork
      count_busy(na, nb, nc);
      begin
        repeat (5) @(posedge clock);
        #1;
        write_enable  = 1'b1; write_address = 8'h05; data_in = 8'h99;
        read_enable   = 1'b1; read_address  = 8'h05;
        @(posedge clock); #1;
        write_enable  = 1'b0; read_enable = 1'b0;
      end
    join
    check("clear_cycles_a", na, 256);
    check("clear_cycles_b", nb, 256);
    check("clear_cycles_c", nc, 256);

    // initial contents, including the location written while busy
    rd_all(8'h00, 9'h000);
    rd_all(8'h7F, 9'h000);
    rd_all(8'hFF, 9'h000);
    rd_all(8'h05, 9'h000);
    repeat (4) @(posedge clock); #1;

    // write then read on the next cycle
    wr(8'h10, 8'hA5);
    rd_all(8'h10, 9'h0A5);
    repeat (4) @(posedge clock); #1;

    // back-to-back reads
    wr(8'h01, 8'h11);
    wr(8'h02, 8'h22);
    wr(8'h03, 8'h33);
    wr(8'h04, 8'h44);
    rd_all(8'h01, 9'h011);
    rd_all(8'h02, 9'h022);
    rd_all(8'h03, 9'h033);
    rd_all(8'h04, 9'h044);
    repeat (5) @(posedge clock); #1;

    // same-address collision
    wr(8'h20, 8'h5A);
    write_enable = 1'b1; write_address = 8'h20; data_in = 8'hC3;
    rd(8'h20, 9'h1C3, 9'h15A, 9'h1C3, 1'b1, 1'b1, 1'b1);
    write_enable = 1'b0;
    rd_all(8'h20, 9'h0C3);
    repeat (5) @(posedge clock); #1;

    // reset one cycle after a read: only the latency-1 instance completes it
    rd(8'h10, 9'h0A5, 9'h000, 9'h000, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("mid_rst_c_dout", c_dout, 8'h00);
    check("mid_rst_c_busy", c_busy, 1);
    check("mid_rst_b_dout", b_dout, 8'h00);
    @(posedge clock); #1;
    reset = 1'b0;
    count_busy(na, nb, nc);
    check("reclear_cycles_a", na, 256);
    check("reclear_cycles_c", nc, 256);
    rd_all(8'h20, 9'h000);
    rd_all(8'h10, 9'h000);

    repeat (8) @(posedge clock);
    check("a_queue_drained", exp_a_q.size(), 0);
    check("b_queue_drained", exp_b_q.size(), 0);
    check("c_queue_drained", exp_c_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
